// File: rtl/i2s_rx_slave.sv
// Slave-mode I2S receiver: oversamples external SCK/WS/SD, deserializes Philips stereo
// frames and queues {left,right} pairs in a show-ahead FIFO with a sticky overrun flag.
module i2s_rx_slave #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          aud_clk_i,
  input  logic                          aud_rst_n_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          ovie_i,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic                          sd_i,
  output logic [2*DATA_WIDTH-1:0]       data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovif_o,
  output logic                          irq_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned FW = 2 * DATA_WIDTH;
  localparam logic [LW-1:0] DepthC = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

  logic [2:0] sck_q;
  logic [1:0] ws_q, sd_q;
  logic       sck_rise, ws_s2, sd_s2, word_end;

  state_e                state_q, state_d;
  logic                  ws_prev_q, ws_prev_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, word;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic                  frame_rdy_q, frame_rdy_d;
  logic [FW-1:0]         frame_q, frame_d;

  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          ovif_q, irq_q;
  logic          pop, full, wr_en, ovf;

  always_ff @(posedge aud_clk_i or negedge aud_rst_n_i) begin
    if (!aud_rst_n_i) begin
      sck_q <= '0;
      ws_q  <= '0;
      sd_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      ws_q  <= {ws_q[0], ws_i};
      sd_q  <= {sd_q[0], sd_i};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ws_s2    = ws_q[1];
  assign sd_s2    = sd_q[1];
  assign word_end = sck_rise & (ws_s2 != ws_prev_q);

  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    left_d      = left_q;
    frame_rdy_d = 1'b0;
    frame_d     = frame_q;
    word        = shreg_q;

    // Bits past DATA_WIDTH match no position and are dropped.
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (cnt_q == 6'(int'(DATA_WIDTH) - 1 - i)) word[i] = sd_s2;
    end

    if (sck_rise) begin
      ws_prev_d = ws_s2;
      if (word_end) begin
        cnt_d   = '0;
        shreg_d = '0;
      end else begin
        cnt_d   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
        shreg_d = word;
      end
    end

    unique case (state_q)
      StIdle: state_d = StSync;
      StSync: if (word_end && ws_prev_q && !ws_s2) state_d = StRun;
      StRun: begin
        if (word_end) begin
          if (!ws_prev_q) begin
            left_d = word;
          end else begin
            frame_rdy_d = 1'b1;
            frame_d     = {left_q, word};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en_i) begin
      state_d     = StIdle;
      frame_rdy_d = 1'b0;
    end else if (clr_i) begin
      state_d     = StSync;
      frame_rdy_d = 1'b0;
    end
  end

  always_ff @(posedge aud_clk_i or negedge aud_rst_n_i) begin
    if (!aud_rst_n_i) begin
      state_q     <= StIdle;
      ws_prev_q   <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      left_q      <= '0;
      frame_rdy_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      ws_prev_q   <= ws_prev_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      left_q      <= left_d;
      frame_rdy_q <= frame_rdy_d;
      frame_q     <= frame_d;
    end
  end

  // A pop frees a slot for a same-cycle write into a full FIFO.
  assign pop   = (level_q != '0) & ready_i;
  assign full  = (level_q == DepthC);
  assign wr_en = frame_rdy_q & (~full | pop) & ~clr_i;
  assign ovf   = frame_rdy_q & full & ~pop;

  always_ff @(posedge aud_clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= frame_q;
  end

  always_ff @(posedge aud_clk_i or negedge aud_rst_n_i) begin
    if (!aud_rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovif_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= ovif_q & ovie_i;
      if (clr_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        ovif_q   <= 1'b0;
      end else begin
        if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        level_q <= level_q + LW'(wr_en) - LW'(pop);
        if (ovf) ovif_q <= 1'b1;
      end
    end
  end

  assign valid_o = (level_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o = level_q;
  assign ovif_o  = ovif_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Bench for i2s_rx_slave: drives Philips I2S words and checks the FIFO outputs every cycle
// against a queue-based frame model plus a few hand-computed expectations.
module tb_i2s_rx_slave;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, ovie = 1'b0, ready = 1'b0;
  logic        sck = 1'b0, ws = 1'b0, sd = 1'b0;
  logic [31:0] data;
  logic        valid, ovif, irq;
  logic [3:0]  level;

  always #5 clk = ~clk;

  i2s_rx_slave #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .aud_clk_i(clk), .aud_rst_n_i(rst_n), .en_i(en), .clr_i(clr), .ovie_i(ovie),
    .sck_i(sck), .ws_i(ws), .sd_i(sd), .data_o(data), .valid_o(valid), .ready_i(ready),
    .level_o(level), .ovif_o(ovif), .irq_o(irq)
  );

  typedef struct {int due; logic [31:0] frame;} pend_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} lit_t;

  pend_t       pend[$];
  logic [31:0] mq[$];
  lit_t        lq[$];
  pend_t       p_cur;
  lit_t        l_cur;
  bit          m_ovif = 0, m_irq = 0, m_en = 0, m_sync = 0, rnd_ready = 0, chk_on = 0;
  bit          has_push, irq_n;
  logic [15:0] m_left = '0;
  int          cyc = 0, last_edge = 0;
  int          total = 0, bad = 0;

  // Reference FIFO: pop first, then accept the scheduled frame if room remains.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete(); pend.delete(); m_ovif = 0; m_irq = 0;
    end else begin
      irq_n    = m_ovif & ovie;
      has_push = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p_cur = pend.pop_front(); has_push = 1;
      end
      if (clr) begin
        mq.delete(); m_ovif = 0;
      end else begin
        if (mq.size() > 0 && ready) void'(mq.pop_front());
        if (has_push) begin
          if (mq.size() < DEPTH) mq.push_back(p_cur.frame);
          else m_ovif = 1;
        end
      end
      m_irq = irq_n;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (lq.size() > 0) begin
      l_cur = lq.pop_front();
      check(l_cur.name, l_cur.act, l_cur.exp);
    end
    if (rst_n && chk_on) begin
      check("valid", 32'(valid), 32'(mq.size() > 0));
      check("level", 32'(level), 32'(mq.size()));
      if (valid && mq.size() > 0) check("data", data, mq[0]);
      check("ovif", 32'(ovif), 32'(m_ovif));
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lq.push_back('{nm, act, exp});
  endtask

  function automatic logic [15:0] fit(input logic [31:0] v, input int n);
    logic [63:0] x;
    x = 64'(v);
    if (n >= 16) x = x >> (n - 16);
    else         x = x << (16 - n);
    return x[15:0];
  endfunction

  function automatic logic [31:0] mask(input logic [31:0] v, input int n);
    return (n >= 32) ? v : (v & ((32'd1 << n) - 32'd1));
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // act: 1 disable, 2 enable, 3 clr pulse, 4 async reset pulse
  task automatic do_act(input int act);
    case (act)
      1: begin en = 1'b0; m_en = 0; m_sync = 0; end
      2: begin en = 1'b1; m_en = 1; m_sync = 0; end
      3: begin clr = 1'b1; wait_cyc(1); clr = 1'b0; m_sync = 0; end
      4: begin
        rst_n = 1'b0; m_sync = 0;
        #1;
        lit("rst_data", data, 32'h0);
        lit("rst_valid", 32'(valid), 32'h0);
        lit("rst_level", 32'(level), 32'h0);
        lit("rst_ovif", 32'(ovif), 32'h0);
        lit("rst_irq", 32'(irq), 32'h0);
        wait_cyc(2);
        rst_n = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic send_bit(input logic w, input logic d, input int act);
    sck = 1'b0; ws = w; sd = d;
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
    do_act(act);
    wait_cyc(2);
    sck = 1'b1; last_edge = cyc;
    wait_cyc(2);
  endtask

  // Philips framing: LSB goes out with the next channel's WS value.
  task automatic send_word(input logic ch, input logic [31:0] v, input int n,
                           input int act_at, input int act);
    for (int i = n - 1; i >= 1; i--) send_bit(ch, v[i], ((n - 1 - i) == act_at) ? act : 0);
    send_bit(~ch, v[0], 0);
    if (m_en) begin
      if (!m_sync) begin
        if (ch) m_sync = 1;
      end else if (!ch) begin
        m_left = fit(v, n);
      end else begin
        pend.push_back('{last_edge + 4, {m_left, fit(v, n)}});
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nl,
                            input int nr);
    send_word(1'b0, l, nl, -1, 0);
    send_word(1'b1, r, nr, -1, 0);
  endtask

  task automatic drain();
    ready = 1'b1; wait_cyc(2 * DEPTH + 4); ready = 1'b0;
  endtask

  int widths[6] = '{8, 12, 16, 20, 24, 32};
  int nl, nr;

  initial begin
    wait_cyc(3);
    lit("reset_data", data, 32'h0);
    lit("reset_valid", 32'(valid), 32'h0);
    lit("reset_level", 32'(level), 32'h0);
    lit("reset_ovif", 32'(ovif), 32'h0);
    lit("reset_irq", 32'(irq), 32'h0);
    rst_n = 1'b1; chk_on = 1; wait_cyc(1);

    // Basic capture after one sync frame
    en = 1'b1; m_en = 1; m_sync = 0;
    send_frame(32'h0F0F, 32'hF0F0, 16, 16);
    send_frame(32'hA5A5, 32'h5A5A, 16, 16);
    wait_cyc(1); lit("cap_valid_early", 32'(valid), 32'h0);
    wait_cyc(1); lit("cap_valid_on", 32'(valid), 32'h1);
    lit("cap_data", data, 32'hA5A55A5A);
    lit("cap_level", 32'(level), 32'h1);
    drain();

    // Disable mid-right-word keeps FIFO contents
    send_frame(32'h0101, 32'h0202, 16, 16);
    send_frame(32'h0303, 32'h0404, 16, 16);
    send_word(1'b0, 32'h0505, 16, -1, 0);
    send_word(1'b1, 32'h0606, 16, 5, 1);
    wait_cyc(8);
    lit("dis_level", 32'(level), 32'h2);
    lit("dis_data", data, 32'h01010202);
    drain();

    // Re-enable mid-left-word: partial frame and next frame are discarded
    send_word(1'b0, 32'h1111, 16, 5, 2);
    send_word(1'b1, 32'h2222, 16, -1, 0);
    send_frame(32'h3333, 32'h4444, 16, 16);
    wait_cyc(4);
    lit("sync_data", data, 32'h33334444);
    lit("sync_level", 32'(level), 32'h1);
    drain();

    // Word width: truncation and zero padding
    send_frame(32'hABCDEF, 32'h123456, 24, 24);
    wait_cyc(4); lit("w24_data", data, 32'hABCD1234);
    drain();
    send_frame(32'hC3, 32'h3C, 8, 8);
    wait_cyc(4); lit("w8_data", data, 32'hC3003C00);
    drain();

    // Overrun, then clear and resync
    ovie = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) send_frame(32'h1000 + i, 32'h2000 + i, 16, 16);
    wait_cyc(4);
    lit("ovr_level", 32'(level), 32'h8);
    lit("ovr_ovif", 32'(ovif), 32'h1);
    lit("ovr_irq", 32'(irq), 32'h1);
    lit("ovr_head", data, 32'h10002000);
    clr = 1'b1; wait_cyc(1); clr = 1'b0; m_sync = 0;
    wait_cyc(1);
    lit("clr_level", 32'(level), 32'h0);
    lit("clr_ovif", 32'(ovif), 32'h0);
    send_frame(32'h5555, 32'h6666, 16, 16);
    wait_cyc(4); lit("resync_level", 32'(level), 32'h0);
    send_frame(32'h7777, 32'h8888, 16, 16);
    wait_cyc(4); lit("resync_data", data, 32'h77778888);
    drain();

    // Full FIFO with a pop in the same cycle as a write
    for (int i = 0; i < DEPTH; i++) send_frame(32'h3000 + i, 32'h4000 + i, 16, 16);
    send_frame(32'h3ABC, 32'h4ABC, 16, 16);
    wait_cyc(1); ready = 1'b1;
    wait_cyc(1); ready = 1'b0;
    lit("fullpop_level", 32'(level), 32'h8);
    lit("fullpop_ovif", 32'(ovif), 32'h0);
    lit("fullpop_head", data, 32'h30014001);
    drain();

    // Asynchronous reset mid-frame
    send_word(1'b0, 32'h7777, 16, 5, 4);
    send_word(1'b1, 32'h8888, 16, -1, 0);
    send_frame(32'h9999, 32'hAAAA, 16, 16);
    wait_cyc(4);
    lit("postrst_data", data, 32'h9999AAAA);
    drain();

    // Random words, widths and back-pressure
    rnd_ready = 1;
    for (int f = 0; f < 25; f++) begin
      nl = widths[$urandom_range(0, 5)];
      nr = widths[$urandom_range(0, 5)];
      send_frame(mask($urandom, nl), mask($urandom, nr), nl, nr);
    end
    rnd_ready = 0;
    drain();
    wait_cyc(2);
    lit("end_level", 32'(level), 32'h0);
    wait_cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
